// File: rtl/myo_spi_pkg.sv
// rtl/myo_spi_pkg.sv - constants, word map and shared types for the myo SPI responder
package myo_spi_pkg;

    localparam int WORD_BITS   = 16;
    localparam int SYNC_STAGES = 2;
    localparam int BIT_CNT_W   = $clog2(WORD_BITS);
    localparam int WORD_CNT_W  = 4;

    localparam logic [WORD_CNT_W-1:0] FRAME_WORDS  = 4'd12;
    localparam logic [WORD_CNT_W-1:0] WORD_CNT_MAX = FRAME_WORDS + 4'd1;
    localparam logic [WORD_BITS-1:0]  SOF_WORD     = 16'h8000;
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT     = BIT_CNT_W'(WORD_BITS - 1);

    localparam logic [WORD_CNT_W-1:0] IDX_SOF     = 4'd0;
    localparam logic [WORD_CNT_W-1:0] IDX_PWM     = 4'd1;
    localparam logic [WORD_CNT_W-1:0] IDX_FLAGS1  = 4'd2;
    localparam logic [WORD_CNT_W-1:0] IDX_FLAGS2  = 4'd3;
    localparam logic [WORD_CNT_W-1:0] IDX_DUMMY   = 4'd4;
    localparam logic [WORD_CNT_W-1:0] IDX_POS_HI  = 4'd5;
    localparam logic [WORD_CNT_W-1:0] IDX_POS_LO  = 4'd6;
    localparam logic [WORD_CNT_W-1:0] IDX_VEL     = 4'd7;
    localparam logic [WORD_CNT_W-1:0] IDX_CUR     = 4'd8;
    localparam logic [WORD_CNT_W-1:0] IDX_SPRING  = 4'd9;
    localparam logic [WORD_CNT_W-1:0] IDX_SENSOR1 = 4'd10;
    localparam logic [WORD_CNT_W-1:0] IDX_SENSOR2 = 4'd11;

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_e;

    typedef struct packed {
        logic [31:0] position;
        logic [15:0] velocity;
        logic [15:0] current;
        logic [15:0] spring;
        logic [15:0] sensor1;
        logic [15:0] sensor2;
    } status_t;

    typedef struct packed {
        logic [15:0] pwm;
        logic [15:0] flags1;
        logic [15:0] flags2;
    } cmd_t;

    // Command slots and indices past the frame end answer with zero.
    function automatic logic [WORD_BITS-1:0] status_word(input status_t s,
                                                         input logic [WORD_CNT_W-1:0] idx);
        case (idx)
            IDX_POS_HI:  return s.position[31:16];
            IDX_POS_LO:  return s.position[15:0];
            IDX_VEL:     return s.velocity;
            IDX_CUR:     return s.current;
            IDX_SPRING:  return s.spring;
            IDX_SENSOR1: return s.sensor1;
            IDX_SENSOR2: return s.sensor2;
            default:     return '0;
        endcase
    endfunction

endpackage

// File: rtl/myo_spi_slave_shifter.sv
// rtl/myo_spi_slave_shifter.sv - SPI mode-0 input sync, edge detect and 16-bit rx/tx shifting
module myo_spi_slave_shifter
    import myo_spi_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sclk,
    input  logic                 ss_n,
    input  logic                 mosi,
    input  logic                 idle,
    input  logic                 active,
    input  logic [WORD_BITS-1:0] tx_word,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 ss_n_high,
    output logic                 word_done,
    output logic                 tx_load,
    output logic                 bit_cnt_zero,
    output logic [WORD_BITS-1:0] rx_word,
    output logic                 miso
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_n_sync_q, ss_n_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, ss_n_prev_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]   rx_q, rx_d, tx_q, tx_d;
    logic                   miso_q, miso_d;
    logic                   sclk_s, ss_n_s, mosi_s, sclk_rise, sclk_fall, shift_ok;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_n_s    = ss_n_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    assign frame_start  = ~ss_n_s & ss_n_prev_q;
    assign frame_end    = ss_n_s & ~ss_n_prev_q;
    assign ss_n_high    = ss_n_s;
    // A deselect in the same cycle as an sclk edge suppresses that edge.
    assign shift_ok     = active & ~frame_end;
    assign rx_word      = {rx_q[WORD_BITS-2:0], mosi_s};
    assign word_done    = shift_ok & sclk_rise & (bit_cnt_q == LAST_BIT);
    assign tx_load      = shift_ok & sclk_fall & (bit_cnt_q == '0);
    assign bit_cnt_zero = (bit_cnt_q == '0);
    assign miso         = miso_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ss_n_sync_d = {ss_n_sync_q[SYNC_STAGES-2:0], ss_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        if (idle && frame_start) begin
            bit_cnt_d = '0;
            tx_d      = '0;
            miso_d    = 1'b0;
        end else if (shift_ok) begin
            if (sclk_rise) begin
                rx_d      = rx_word;
                bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
            end
            if (sclk_fall) begin
                if (bit_cnt_q == '0) begin
                    tx_d   = tx_word;
                    miso_d = tx_word[WORD_BITS-1];
                end else begin
                    tx_d   = {tx_q[WORD_BITS-2:0], 1'b0};
                    miso_d = tx_q[WORD_BITS-2];
                end
            end
        end
        if (!shift_ok) begin
            miso_d = 1'b0;
        end
    end

    // Sync chains reset low so WAIT_IDLE only leaves on a genuinely high ss_n.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync_q <= '0;
            ss_n_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_n_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_n_sync_q <= ss_n_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_s;
            ss_n_prev_q <= ss_n_s;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
        end
    end

endmodule

// File: rtl/myo_spi_responder.sv
// rtl/myo_spi_responder.sv - myo SPI frame FSM: status snapshot, command decode and atomic commit
module myo_spi_responder
    import myo_spi_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        sclk,
    input  logic                        ss_n,
    input  logic                        mosi,
    output logic                        miso,
    input  logic [31:0]                 actual_position,
    input  logic [WORD_BITS-1:0]        actual_velocity,
    input  logic [WORD_BITS-1:0]        actual_current,
    input  logic [WORD_BITS-1:0]        spring_displacement,
    input  logic [WORD_BITS-1:0]        sensor1,
    input  logic [WORD_BITS-1:0]        sensor2,
    output logic signed [WORD_BITS-1:0] pwm_ref,
    output logic [WORD_BITS-1:0]        control_flags1,
    output logic [WORD_BITS-1:0]        control_flags2,
    output logic                        cmd_valid,
    output logic                        frame_error,
    output logic                        busy
);

    state_e                state_q, state_d;
    status_t               status_sh_q, status_sh_d;
    cmd_t                  cmd_sh_q, cmd_sh_d, cmd_q, cmd_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic                  err_q, err_d;
    logic                  cmd_valid_q, cmd_valid_d, frame_error_q, frame_error_d;
    logic                  busy_q, busy_d;
    logic                  frame_start, frame_end, ss_n_high, word_done, tx_load, bit_cnt_zero;
    logic [WORD_BITS-1:0]  rx_word, tx_word;

    myo_spi_slave_shifter u_shifter (
        .clock        (clock),
        .reset        (reset),
        .sclk         (sclk),
        .ss_n         (ss_n),
        .mosi         (mosi),
        .idle         (state_q == IDLE),
        .active       (state_q == SHIFT),
        .tx_word      (tx_word),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .ss_n_high    (ss_n_high),
        .word_done    (word_done),
        .tx_load      (tx_load),
        .bit_cnt_zero (bit_cnt_zero),
        .rx_word      (rx_word),
        .miso         (miso)
    );

    // word_cnt_q already points at the next word by the time the shifter asks for it.
    assign tx_word = tx_load ? status_word(status_sh_q, word_cnt_q) : '0;

    always_comb begin
        state_d       = state_q;
        status_sh_d   = status_sh_q;
        cmd_sh_d      = cmd_sh_q;
        cmd_d         = cmd_q;
        word_cnt_d    = word_cnt_q;
        err_d         = err_q;
        cmd_valid_d   = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (ss_n_high) state_d = IDLE;
            end
            IDLE: begin
                if (frame_start) begin
                    state_d     = SHIFT;
                    status_sh_d = '{actual_position, actual_velocity, actual_current,
                                    spring_displacement, sensor1, sensor2};
                    word_cnt_d  = '0;
                    err_d       = 1'b0;
                end
            end
            SHIFT: begin
                if (frame_end) begin
                    state_d = IDLE;
                    if (word_cnt_q == FRAME_WORDS && bit_cnt_zero && !err_q) begin
                        cmd_d       = cmd_sh_q;
                        cmd_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else if (word_done) begin
                    case (word_cnt_q)
                        IDX_SOF:    if (rx_word != SOF_WORD) err_d = 1'b1;
                        IDX_PWM:    cmd_sh_d.pwm    = rx_word;
                        IDX_FLAGS1: cmd_sh_d.flags1 = rx_word;
                        IDX_FLAGS2: cmd_sh_d.flags2 = rx_word;
                        IDX_DUMMY:  ;
                        default:    if (word_cnt_q >= FRAME_WORDS) err_d = 1'b1;
                    endcase
                    if (word_cnt_q != WORD_CNT_MAX) word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= WAIT_IDLE;
            status_sh_q   <= '0;
            cmd_sh_q      <= '0;
            cmd_q         <= '0;
            word_cnt_q    <= '0;
            err_q         <= 1'b0;
            cmd_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            status_sh_q   <= status_sh_d;
            cmd_sh_q      <= cmd_sh_d;
            cmd_q         <= cmd_d;
            word_cnt_q    <= word_cnt_d;
            err_q         <= err_d;
            cmd_valid_q   <= cmd_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    assign pwm_ref        = $signed(cmd_q.pwm);
    assign control_flags1 = cmd_q.flags1;
    assign control_flags2 = cmd_q.flags2;
    assign cmd_valid      = cmd_valid_q;
    assign frame_error    = frame_error_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_myo_spi_responder.sv
// tb/tb_myo_spi_responder.sv - directed and random SPI frames checked against a frame-level model
module tb_myo_spi_responder;

    localparam int HALF = 5;

    logic        clock = 1'b0;
    logic        reset, sclk, ss_n, mosi, miso;
    logic [31:0] act_pos;
    logic [15:0] act_vel, act_cur, act_spring, act_s1, act_s2;
    logic [15:0] pwm_ref, control_flags1, control_flags2;
    logic        cmd_valid, frame_error, busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] tx_words [16];
    logic [15:0] m_pwm = 16'h0, m_f1 = 16'h0, m_f2 = 16'h0;
    int          hook_word = -1;
    int          hook_kind = 0;
    logic [15:0] hook_val = 16'h0;

    myo_spi_responder dut (
        .clock               (clock),
        .reset               (reset),
        .sclk                (sclk),
        .ss_n                (ss_n),
        .mosi                (mosi),
        .miso                (miso),
        .actual_position     (act_pos),
        .actual_velocity     (act_vel),
        .actual_current      (act_cur),
        .spring_displacement (act_spring),
        .sensor1             (act_s1),
        .sensor2             (act_s2),
        .pwm_ref             (pwm_ref),
        .control_flags1      (control_flags1),
        .control_flags2      (control_flags2),
        .cmd_valid           (cmd_valid),
        .frame_error         (frame_error),
        .busy                (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, observed running required done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, miso, 0);
        check({tag, "_pwm"}, pwm_ref, 0);
        check({tag, "_f1"}, control_flags1, 0);
        check({tag, "_f2"}, control_flags2, 0);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_frame_error"}, frame_error, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic set_cmd(input logic [15:0] sof, input logic [15:0] pwm,
                           input logic [15:0] f1, input logic [15:0] f2);
        for (int i = 0; i < 16; i++) tx_words[i] = 16'h0000;
        tx_words[0] = sof;
        tx_words[1] = pwm;
        tx_words[2] = f1;
        tx_words[3] = f2;
    endtask

    // nwords full words, then last_bits bits of one partial word, then deselect.
    task automatic run_frame(input string tag, input int nwords, input int last_bits);
        logic [15:0] st [7];
        logic [15:0] rxw, expw;
        int          total, nb, cv_cnt, fe_cnt, cv_at, rst_w;
        bit          valid;
        st    = '{act_pos[31:16], act_pos[15:0], act_vel, act_cur, act_spring, act_s1, act_s2};
        rst_w = (hook_kind == 2) ? hook_word : -1;
        total = nwords + ((last_bits > 0) ? 1 : 0);
        ss_n  = 1'b0;
        repeat (HALF) @(negedge clock);
        for (int w = 0; w < total; w++) begin
            if (w == hook_word && hook_kind == 1) act_vel = hook_val;
            if (w == hook_word && hook_kind == 2) begin
                reset = 1'b1;
                repeat (3) @(negedge clock);
                check_reset_outputs({tag, "_midreset"});
                reset = 1'b0;
                m_pwm = 16'h0; m_f1 = 16'h0; m_f2 = 16'h0;
            end
            if (w == 1) check({tag, "_busy_mid"}, busy, 1);
            if (w == 10) check({tag, "_pwm_hold"}, pwm_ref, m_pwm);
            nb  = (w < nwords) ? 16 : last_bits;
            rxw = 16'h0;
            for (int b = 0; b < nb; b++) begin
                mosi = tx_words[w][15-b];
                repeat (HALF) @(negedge clock);
                rxw[15-b] = miso;
                sclk = 1'b1;
                repeat (HALF) @(negedge clock);
                sclk = 1'b0;
            end
            if (w < nwords) begin
                if (rst_w >= 0 && w >= rst_w)  expw = 16'h0;
                else if (w >= 5 && w <= 11)    expw = st[w-5];
                else                           expw = 16'h0;
                check($sformatf("%s_miso_w%0d", tag, w), rxw, expw);
            end
        end
        repeat (HALF) @(negedge clock);
        ss_n   = 1'b1;
        cv_cnt = 0; fe_cnt = 0; cv_at = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (cmd_valid === 1'b1) begin cv_cnt++; cv_at = i; end
            if (frame_error === 1'b1) fe_cnt++;
        end
        valid = (nwords == 12) && (last_bits == 0) && (tx_words[0] == 16'h8000) && (rst_w < 0);
        if (rst_w >= 0) begin
            check({tag, "_cmd_valid_cnt"}, cv_cnt, 0);
            check({tag, "_frame_error_cnt"}, fe_cnt, 0);
        end else if (valid) begin
            check({tag, "_cmd_valid_cnt"}, cv_cnt, 1);
            check({tag, "_frame_error_cnt"}, fe_cnt, 0);
            check({tag, "_cmd_valid_latency"}, cv_at, 3);
            m_pwm = tx_words[1]; m_f1 = tx_words[2]; m_f2 = tx_words[3];
        end else begin
            check({tag, "_cmd_valid_cnt"}, cv_cnt, 0);
            check({tag, "_frame_error_cnt"}, fe_cnt, 1);
        end
        check({tag, "_pwm"}, pwm_ref, m_pwm);
        check({tag, "_f1"}, control_flags1, m_f1);
        check({tag, "_f2"}, control_flags2, m_f2);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_miso_end"}, miso, 0);
        repeat (10) @(negedge clock);
        hook_kind = 0;
        hook_word = -1;
    endtask

    initial begin
        int kind, n;
        reset = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        act_pos = 32'h0; act_vel = 16'h0; act_cur = 16'h0;
        act_spring = 16'h0; act_s1 = 16'h0; act_s2 = 16'h0;
        repeat (4) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (6) @(negedge clock);

        act_pos = 32'h12345678; act_vel = 16'h0010; act_cur = 16'h0020;
        act_spring = 16'hFFF0; act_s1 = 16'h0AAA; act_s2 = 16'h0555;
        set_cmd(16'h8000, 16'h01F4, 16'h0003, 16'h0000);
        run_frame("t1_valid", 12, 0);

        set_cmd(16'h0000, 16'h0BAD, 16'h0BAD, 16'h0BAD);
        run_frame("t2_badsof", 12, 0);

        set_cmd(16'h8000, 16'h1111, 16'h2222, 16'h3333);
        run_frame("t3_partial", 3, 7);
        set_cmd(16'h8000, 16'hFF38, 16'h0005, 16'h0006);
        run_frame("t3_recover", 12, 0);

        act_vel = 16'h0010;
        hook_word = 2; hook_kind = 1; hook_val = 16'h7FFF;
        run_frame("t4_snapshot", 12, 0);
        run_frame("t4_next", 12, 0);

        set_cmd(16'h8000, 16'h4444, 16'h5555, 16'h6666);
        tx_words[12] = 16'hA5C3;
        run_frame("t5_extra", 13, 0);

        set_cmd(16'h8000, 16'h7777, 16'h8888, 16'h9999);
        hook_word = 6; hook_kind = 2;
        run_frame("t6_reset", 12, 0);
        set_cmd(16'h8000, 16'h0123, 16'h0456, 16'h0789);
        run_frame("t6_after", 12, 0);

        for (int r = 0; r < 6; r++) begin
            kind = $urandom_range(0, 3);
            act_pos = $urandom; act_vel = 16'($urandom); act_cur = 16'($urandom);
            act_spring = 16'($urandom); act_s1 = 16'($urandom); act_s2 = 16'($urandom);
            set_cmd((kind == 2) ? 16'($urandom_range(0, 16'h7FFF)) : 16'h8000,
                    16'($urandom), 16'($urandom), 16'($urandom));
            for (int w = 4; w < 13; w++) tx_words[w] = 16'($urandom);
            n = (kind == 3) ? (($urandom_range(0, 1) == 1) ? 13 : 11) : 12;
            run_frame($sformatf("rand%0d", r), n, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
